// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
// clock, LSB first, using a full subtractor built from two half_subtractor
// cells and a registered borrow. The start/busy/done handshake frames each
// operation. The results are held in output registers, so they stay stable
// while the next operation runs.

// Single-bit half subtractor: diff = a - b, borrow set when a=0 and b=1.
module half_subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic diff_o,
    output logic borrow_o
);
    assign diff_o   = a_i ^ b_i;
    assign borrow_o = ~a_i & b_i;
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_out_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d1, w1, d2, w2;
    logic [WIDTH-1:0] res_shifted;
    logic             br_next;

    // First slice subtracts the operand bits, second slice subtracts the
    // borrow carried from the previous bit position.
    half_subtractor u_hs_ab (
        .a_i      (a_sh_q[0]),
        .b_i      (b_sh_q[0]),
        .diff_o   (d1),
        .borrow_o (w1)
    );

    half_subtractor u_hs_br (
        .a_i      (d1),
        .b_i      (br_q),
        .diff_o   (d2),
        .borrow_o (w2)
    );

    // The new result bit enters at the MSB so that after WIDTH shifts the
    // LSB-first bits end up in their natural positions.
    assign res_shifted = (res_sh_q >> 1) | (WIDTH'(d2) << (WIDTH - 1));
    assign br_next     = w1 | w2;

    // Next-state and datapath decisions for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_shifted;
                br_d     = br_next;
                if (cnt_q == LAST_BIT) begin
                    // Hold the counter on the final bit so it never wraps.
                    diff_d   = res_shifted;
                    borrow_d = br_next;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign diff_o       = diff_q;
    assign borrow_out_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. An 8-bit instance is driven
// through a scoreboard: the expected {borrow, diff} is queued when an
// operation is accepted and is popped when done pulses. A 1-bit instance
// covers the degenerate width.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;

    logic         start8;
    logic [W-1:0] a8, b8;
    logic         busy8, done8, borrow8;
    logic [W-1:0] diff8;

    logic         start1;
    logic [0:0]   a1, b1;
    logic         busy1, done1, borrow1;
    logic [0:0]   diff1;

    int           errors;
    int           checks;
    int           doneCount;
    int           cyc;
    logic [W:0]   expQ[$];
    logic [W-1:0] lastDiff;
    logic         lastBorrow;

    serial_subtractor #(.WIDTH(W)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start8),
        .a_i          (a8),
        .b_i          (b8),
        .busy_o       (busy8),
        .done_o       (done8),
        .diff_o       (diff8),
        .borrow_out_o (borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start1),
        .a_i          (a1),
        .b_i          (b1),
        .busy_o       (busy1),
        .done_o       (done1),
        .diff_o       (diff1),
        .borrow_out_o (borrow1)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to measure done spacing.
    always @(posedge clk) cyc++;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: whenever done pulses, compare against the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checkOutput("spuriousDone", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = expQ.pop_front();
                checkOutput("diff", 32'(diff8), 32'(e[W-1:0]));
                checkOutput("borrow", 32'(borrow8), 32'(e[W]));
                lastDiff   = e[W-1:0];
                lastBorrow = e[W];
            end
        end
    end

    // Reference result for the 8-bit instance.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {(a < b), d};
    endfunction

    // Advance at least one negedge, then keep going until done is seen or the budget runs out.
    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done8 && lat < 30);
        if (!done8) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    // One isolated operation: pulse start, confirm busy and output hold, then check done latency.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        expQ.push_back(model(a, b));
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("busyAfterStart", 32'(busy8), 32'd1);
        checkOutput("holdDiff", 32'(diff8), 32'(lastDiff));
        checkOutput("holdBorrow", 32'(borrow8), 32'(lastBorrow));
        waitDone(lat);
        checkOutput("latency", 32'(lat), 32'(W));
    endtask

    // Main sequence covering reset, normal operation, ignored start, back-to-back and mid-run reset.
    initial begin
        int lat;
        int dc;
        int tPrev;
        errors     = 0;
        checks     = 0;
        doneCount  = 0;
        cyc        = 0;
        lastDiff   = '0;
        lastBorrow = 1'b0;
        start8     = 1'b0;
        a8         = '0;
        b8         = '0;
        start1     = 1'b0;
        a1         = '0;
        b1         = '0;
        rst_n      = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rstBusy", 32'(busy8), 32'd0);
        checkOutput("rstDone", 32'(done8), 32'd0);
        checkOutput("rstDiff", 32'(diff8), 32'd0);
        checkOutput("rstBorrow", 32'(borrow8), 32'd0);
        rst_n = 1'b1;

        // Basic cases, including borrow and equal operands.
        applyStimulus(8'h5A, 8'h3C);
        applyStimulus(8'h00, 8'h01);
        applyStimulus(8'hA5, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // A start pulse in the middle of RUN is ignored.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h01;
        expQ.push_back(model(8'h10, 8'h01));
        dc = doneCount;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'h00;
        @(negedge clk);
        start8 = 1'b0;
        waitDone(lat);
        checkOutput("ignoredStartLatency", 32'(lat), 32'd5);
        repeat (15) @(negedge clk);
        checkOutput("ignoredStartDones", 32'(doneCount), 32'(dc + 1));
        checkOutput("ignoredStartQueue", 32'(expQ.size()), 32'd0);

        // start held high: one result every WIDTH+1 cycles, busy low during DONE.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h80;
        b8     = 8'h7F;
        expQ.push_back(model(8'h80, 8'h7F));
        tPrev = cyc;
        for (int k = 0; k < 3; k++) begin
            waitDone(lat);
            checkOutput("b2bSpacing", 32'(lat), 32'(W + 1));
            checkOutput("b2bCycles", 32'(cyc - tPrev), 32'(W + 1));
            checkOutput("b2bBusyLow", 32'(busy8), 32'd0);
            tPrev = cyc;
            if (k < 2) expQ.push_back(model(8'h80, 8'h7F));
            else       start8 = 1'b0;
        end
        @(negedge clk);
        checkOutput("b2bIdle", 32'(busy8), 32'd0);
        checkOutput("b2bQueue", 32'(expQ.size()), 32'd0);

        // Reset in the middle of RUN clears everything and produces no done.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h33;
        b8     = 8'h44;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        dc    = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 32'(busy8), 32'd0);
        checkOutput("midRstDone", 32'(done8), 32'd0);
        checkOutput("midRstDiff", 32'(diff8), 32'd0);
        checkOutput("midRstBorrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        lastDiff   = '0;
        lastBorrow = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("midRstNoDone", 32'(doneCount), 32'(dc));
        applyStimulus(8'h44, 8'h33);

        // Single-bit instance: all four operand combinations.
        for (int i = 0; i < 4; i++) begin
            int ai;
            int bi;
            ai = (i >> 1) & 1;
            bi = i & 1;
            @(negedge clk);
            start1 = 1'b1;
            a1     = 1'(ai);
            b1     = 1'(bi);
            @(negedge clk);
            start1 = 1'b0;
            checkOutput("w1Busy", 32'(busy1), 32'd1);
            checkOutput("w1DoneEarly", 32'(done1), 32'd0);
            @(negedge clk);
            checkOutput("w1Done", 32'(done1), 32'd1);
            checkOutput("w1Diff", 32'(diff1), 32'((ai - bi) & 1));
            checkOutput("w1Borrow", 32'(borrow1), 32'(ai < bi));
            @(negedge clk);
            checkOutput("w1DonePulse", 32'(done1), 32'd0);
        end

        checkOutput("finalQueue", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial WIDTH-bit unsigned subtractor computing a − b, LSB first, one bit per clock.
- Each bit slice is a full subtractor built from two half_subtractor instances plus a registered borrow.
- Sits downstream of the half_subtractor cell: it consumes that cell's diff/borrow outputs each cycle and accumulates them into a multi-bit result.
- Reported with a start/busy/done handshake.

## Interface

- WIDTH, 8, operand and result width in bits (legal range ≥ 1).
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising edge of clk.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff/borrow_out update.
- diff  output  WIDTH  result (a − b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned.

## Operation

**State machine: IDLE, RUN, DONE**
- IDLE: if start=1, then in the same edge:
  - load a_sh←a, b_sh←b;
  - clear borrow register br←0;
  - clear bit counter cnt←0;
  - go to RUN.
- RUN, per cycle:
  - Slice 1: half_subtractor on (a_sh[0], b_sh[0]) gives d1, w1.
  - Slice 2: half_subtractor on (d1, br) gives d2, w2.
  - Register updates:
    - res_sh ← {d2, res_sh[WIDTH-1:1]};
    - br ← w1 | w2;
    - a_sh, b_sh shift right by 1;
    - cnt ← cnt + 1.
  - When cnt = WIDTH−1 at the edge, go to DONE.
- DONE (exactly one cycle):
  - done=1; diff and borrow_out were loaded from res_sh/br on the edge entering DONE.
  - If start=1 in this cycle, load new operands and go directly to RUN (back-to-back).
  - Otherwise go to IDLE.

**Control and output rules**
- start is ignored while in RUN; no queuing, no error flag.
- diff and borrow_out are output registers separate from the working registers.
  - They change only on the edge entering DONE.
  - They hold their value through IDLE and through the next RUN.
- busy = 1 in RUN only. done = 1 in DONE only.
- cnt width is max(1, $clog2(WIDTH)). The counter never wraps within a run.
- Arithmetic is unsigned modular. The subtraction always completes; no overflow flag.
  - Signed interpretation is left to the consumer.

**Reset (rst_n=0, any time including mid-RUN)**
- All of the following go to 0 immediately: diff, borrow_out, done, busy, a_sh, b_sh, res_sh, br, cnt.
- State goes to IDLE.
- The in-flight operation is discarded and no done is generated for it.
- After rst_n rises, the first edge with start=1 begins a new operation normally.

## Timing

- Reset values: busy=0, done=0, diff=0, borrow_out=0.
- Latency, with start sampled at edge E0:
  - busy is high after E0 for WIDTH cycles (edges E1..E_WIDTH).
  - done is high for the cycle following edge E_WIDTH.
  - diff is valid from that edge onward.
  - Total: WIDTH+1 edges from the start edge to the end of the done cycle.
- Throughput with back-to-back start (held high or asserted during DONE): one result per WIDTH+1 cycles.
- WIDTH=1: RUN lasts exactly one cycle; done follows on the next cycle.
- Combinational paths: none from inputs to outputs. All outputs are registered.

## Test plan

1. WIDTH=8, a=0x5A, b=0x3C, one-cycle start → busy for 8 cycles, then done pulse; diff=0x1E, borrow_out=0.
2. WIDTH=8, a=0x00, b=0x01 → diff=0xFF, borrow_out=1. Then a=0xA5, b=0xA5 → diff=0x00, borrow_out=0. Previous result holds until the second done.
3. start pulsed with a=0x10, b=0x01; during cycle 3 of RUN, pulse start with a=0xFF, b=0x00 → exactly one done; diff=0x0F; the second request is ignored.
4. start held high continuously with fixed a=0x80, b=0x7F → done every 9 cycles, diff=0x01 each time, busy low only during DONE cycles.
5. Assert rst_n=0 mid-RUN (cycle 4) of a=0x33, b=0x44 → all outputs 0 immediately, no done; after release, a=0x44, b=0x33 → diff=0x11, borrow_out=0.
6. WIDTH=1, all four (a,b) combinations → (diff,borrow_out) = 00→(0,0), 01→(1,1), 10→(1,0), 11→(0,0), each with done 2 edges after start.
